// File: rtl/stk_next_ptr_mem_pkg.sv
// stk_next_ptr_mem_pkg: shared state type and power-on table contents for the next-pointer table
package stk_next_ptr_mem_pkg;
  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;
  // Chain mode links each entry to its successor; the last entry points at itself as end marker
  function automatic int init_value(int i, int n, bit chain);
    return chain ? ((i == n - 1) ? i : i + 1) : 0;
  endfunction
endpackage

// File: rtl/generic_sram_1r1w.sv
// generic_sram_1r1w: one-read one-write array, read-first, registered read data
module generic_sram_1r1w #(
  parameter int W = 8,
  parameter int N = 256,
  parameter int A = $clog2(N)
) (
  input  logic         clk,
  input  logic         we_i,
  input  logic [A-1:0] waddr_i,
  input  logic [W-1:0] wdata_i,
  input  logic         re_i,
  input  logic [A-1:0] raddr_i,
  output logic [W-1:0] rdata_o
);
  logic [W-1:0] mem_q [N];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/stk_next_ptr_mem.sv
// stk_next_ptr_mem: self-initialising next-pointer table with write-to-read bypass
// and out-of-range detection for the stack pipeline memory stage
module stk_next_ptr_mem
  import stk_next_ptr_mem_pkg::*;
#(
  parameter int N          = 1024,
  parameter int W          = $clog2(N),
  parameter bit INIT_CHAIN = 1'b1
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         i_init,
  output logic         o_rdy,
  input  logic         i_rd_vld,
  input  logic [W-1:0] i_rd_addr,
  output logic         o_rd_vld,
  output logic [W-1:0] o_rd_data,
  input  logic         i_wr_vld,
  input  logic [W-1:0] i_wr_addr,
  input  logic [W-1:0] i_wr_data,
  output logic         o_oor
);
  localparam logic [W:0] NUM = (W+1)'(N);
  state_t state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d, byp_data_q, hold_q, resp, mem_rdata, mem_waddr, mem_wdata;
  logic rd_vld_q, rd_oor_q, oor_q, byp_q;
  logic rd_acc, wr_acc, rd_in, wr_in, last, mem_we;
  assign o_rdy  = state_q == RUN;
  assign rd_acc = i_rd_vld & o_rdy;
  assign wr_acc = i_wr_vld & o_rdy;
  assign rd_in  = {1'b0, i_rd_addr} < NUM;
  assign wr_in  = {1'b0, i_wr_addr} < NUM;
  assign last   = cnt_q == W'(N - 1);
  assign state_d = o_rdy ? (i_init ? INIT : RUN) : (last ? RUN : INIT);
  assign cnt_d   = (o_rdy | last) ? '0 : cnt_q + 1'b1;
  // While initialising the write port belongs to the counter; out-of-range writes never reach the array
  assign mem_we    = ~o_rdy | (wr_acc & wr_in);
  assign mem_waddr = o_rdy ? i_wr_addr : cnt_q;
  assign mem_wdata = o_rdy ? i_wr_data : W'(init_value(int'(cnt_q), N, INIT_CHAIN));
  generic_sram_1r1w #(.W(W), .N(N)) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .re_i    (rd_acc & rd_in),
    .raddr_i (i_rd_addr),
    .rdata_o (mem_rdata)
  );
  // The array is read-first, so a same-address write in the read cycle is served from the bypass register
  assign resp      = rd_oor_q ? '0 : (byp_q ? byp_data_q : mem_rdata);
  assign o_rd_vld  = rd_vld_q;
  assign o_rd_data = rd_vld_q ? resp : hold_q;
  assign o_oor     = oor_q;
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= INIT;
      cnt_q      <= '0;
      rd_vld_q   <= 1'b0;
      rd_oor_q   <= 1'b0;
      oor_q      <= 1'b0;
      byp_q      <= 1'b0;
      byp_data_q <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_vld_q   <= rd_acc;
      rd_oor_q   <= rd_acc & ~rd_in;
      oor_q      <= (rd_acc & ~rd_in) | (wr_acc & ~wr_in);
      byp_q      <= rd_acc & wr_acc & wr_in & (i_rd_addr == i_wr_addr);
      byp_data_q <= i_wr_data;
      if (rd_vld_q) hold_q <= o_rd_data;
    end
  end
endmodule

// File: tb/tb_stk_next_ptr_mem.sv
// tb_stk_next_ptr_mem: table-driven scoreboard bench over three parameterisations
// (N=8 chain, N=6 chain, N=8 zero-fill) sharing one clock, reset and i_init
module tb_stk_next_ptr_mem;
  typedef struct {
    int         idx;
    logic       init, rd, wr;
    logic [2:0] ra, wa, wd;
    logic       evld;
    logic [2:0] edat;
    logic       eoor;
  } vec_t;
  typedef struct {
    int         idx;
    logic       vld;
    logic [2:0] dat;
    logic       oor;
    string      nm;
  } exp_t;
  logic clk = 1'b0, arst_n = 1'b0, init = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [2:0] sel = '0, ra = '0, wa = '0, wd = '0;
  logic [2:0] rdy, rvld, oor;
  logic [2:0] rdat [3];
  exp_t sb[$];
  vec_t tbl[$];
  int n_vec = 0, n_bad = 0;
  always #5 clk = ~clk;
  stk_next_ptr_mem #(.N(8), .INIT_CHAIN(1'b1)) u8 (
    .clk(clk), .arst_n(arst_n), .i_init(init), .o_rdy(rdy[0]),
    .i_rd_vld(rd & sel[0]), .i_rd_addr(ra), .o_rd_vld(rvld[0]), .o_rd_data(rdat[0]),
    .i_wr_vld(wr & sel[0]), .i_wr_addr(wa), .i_wr_data(wd), .o_oor(oor[0]));
  stk_next_ptr_mem #(.N(6), .INIT_CHAIN(1'b1)) u6 (
    .clk(clk), .arst_n(arst_n), .i_init(init), .o_rdy(rdy[1]),
    .i_rd_vld(rd & sel[1]), .i_rd_addr(ra), .o_rd_vld(rvld[1]), .o_rd_data(rdat[1]),
    .i_wr_vld(wr & sel[1]), .i_wr_addr(wa), .i_wr_data(wd), .o_oor(oor[1]));
  stk_next_ptr_mem #(.N(8), .INIT_CHAIN(1'b0)) uz (
    .clk(clk), .arst_n(arst_n), .i_init(init), .o_rdy(rdy[2]),
    .i_rd_vld(rd & sel[2]), .i_rd_addr(ra), .o_rd_vld(rvld[2]), .o_rd_data(rdat[2]),
    .i_wr_vld(wr & sel[2]), .i_wr_addr(wa), .i_wr_data(wd), .o_oor(oor[2]));
  task automatic chk(string nm, logic [2:0] act, logic [2:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask
  function automatic vec_t mk(int idx, bit r, int ra_, bit w, int wa_, int wd_, bit ev, int ed, bit eo);
    vec_t v;
    v.idx = idx; v.init = 1'b0; v.rd = r; v.wr = w;
    v.ra = 3'(ra_); v.wa = 3'(wa_); v.wd = 3'(wd_);
    v.evld = ev; v.edat = 3'(ed); v.eoor = eo;
    return v;
  endfunction
  // Drive one request cycle, queue its expected response, compare after the edge
  task automatic run(vec_t v, string nm);
    exp_t e;
    sel = 3'(1 << v.idx); init = v.init; rd = v.rd; wr = v.wr; ra = v.ra; wa = v.wa; wd = v.wd;
    e.idx = v.idx; e.vld = v.evld; e.dat = v.edat; e.oor = v.eoor; e.nm = nm;
    sb.push_back(e);
    @(negedge clk);
    init = 1'b0; rd = 1'b0; wr = 1'b0;
    e = sb.pop_front();
    chk({e.nm, ".vld"}, 3'(rvld[e.idx]), 3'(e.vld));
    chk({e.nm, ".data"}, rdat[e.idx], e.dat);
    chk({e.nm, ".oor"}, 3'(oor[e.idx]), 3'(e.oor));
  endtask
  // k edges after reset release / init start: ready only once all entries are written
  task automatic init_count(string nm, bit poke);
    for (int k = 0; k <= 8; k++) begin
      for (int j = 0; j < 3; j++)
        chk($sformatf("%s.rdy%0d.c%0d", nm, j, k), 3'(rdy[j]), 3'(k >= (j == 1 ? 6 : 8)));
      if (poke && k == 2) init = 1'b1;
      @(negedge clk);
      init = 1'b0;
    end
  endtask
  initial begin
    vec_t v;
    for (int i = 0; i < 8; i++) tbl.push_back(mk(0, 1, i, 0, 0, 0, 1, i == 7 ? 7 : i + 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 3, 5, 0, 7, 0));
    tbl.push_back(mk(0, 1, 3, 0, 0, 0, 1, 5, 0));
    tbl.push_back(mk(0, 1, 2, 1, 2, 6, 1, 6, 0));
    tbl.push_back(mk(0, 1, 2, 0, 0, 0, 1, 6, 0));
    tbl.push_back(mk(0, 1, 4, 1, 2, 1, 1, 5, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 5, 0));
    tbl.push_back(mk(1, 1, 5, 0, 0, 0, 1, 5, 0));
    tbl.push_back(mk(1, 1, 7, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 6, 1, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 6, 1, 6, 3, 1, 0, 1));
    for (int i = 0; i < 6; i++) tbl.push_back(mk(1, 1, i, 0, 0, 0, 1, i == 5 ? 5 : i + 1, 0));
    tbl.push_back(mk(1, 1, 3, 1, 6, 2, 1, 4, 1));
    tbl.push_back(mk(2, 0, 0, 1, 4, 2, 0, 0, 0));
    tbl.push_back(mk(2, 1, 4, 0, 0, 0, 1, 2, 0));
    tbl.push_back(mk(2, 1, 7, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(2, 1, 4, 1, 4, 3, 1, 3, 0));
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("rst.rdy%0d", j), 3'(rdy[j]), 3'd0);
      chk($sformatf("rst.vld%0d", j), 3'(rvld[j]), 3'd0);
      chk($sformatf("rst.data%0d", j), rdat[j], 3'd0);
      chk($sformatf("rst.oor%0d", j), 3'(oor[j]), 3'd0);
    end
    arst_n = 1'b1;
    init_count("boot", 1'b0);
    foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));
    // i_init together with a read: the read still answers, then the table rebuilds
    v = mk(0, 1, 3, 0, 0, 0, 1, 5, 0);
    v.init = 1'b1;
    run(v, "init_rd");
    init_count("reinit", 1'b1);
    for (int i = 0; i < 8; i++) run(mk(0, 1, i, 0, 0, 0, 1, i == 7 ? 7 : i + 1, 0), $sformatf("chain%0d", i));
    for (int i = 0; i < 8; i++) run(mk(2, 1, i, 0, 0, 0, 1, 0, 0), $sformatf("zero%0d", i));
    run(mk(0, 0, 0, 1, 6, 2, 0, 7, 0), "wr6");
    run(mk(0, 1, 6, 0, 0, 0, 1, 2, 0), "rd6");
    // Response already launched when reset hits must vanish
    sel = 3'b001; rd = 1'b1; ra = 3'd1;
    @(posedge clk);
    #1 arst_n = 1'b0;
    rd = 1'b0;
    @(negedge clk);
    chk("flight.vld", 3'(rvld[0]), 3'd0);
    chk("flight.data", rdat[0], 3'd0);
    chk("flight.rdy", 3'(rdy[0]), 3'd0);
    arst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("mid.rdy.c%0d", k), 3'(rdy[0]), 3'd0);
      @(negedge clk);
    end
    #2 arst_n = 1'b0;
    @(negedge clk);
    chk("mid.rst.rdy", 3'(rdy[0]), 3'd0);
    arst_n = 1'b1;
    init_count("rst2", 1'b0);
    run(mk(0, 1, 6, 0, 0, 0, 1, 7, 0), "post6");
    run(mk(0, 1, 0, 0, 0, 0, 1, 1, 0), "post0");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
